// File: rtl/gate_stream_evaluator.sv
// Streaming gate-level netlist evaluator: primary inputs are loaded into a one-bit
// net table, then gate records are evaluated one per cycle against that table.
module gate_stream_evaluator #(
    parameter int unsigned NET_W = 7,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   pi_we,
    input  logic [NET_W-1:0]       pi_id,
    input  logic                   pi_val,
    input  logic                   go_eval,
    input  logic                   g_valid,
    output logic                   g_ready,
    input  logic [3+3*NET_W-1:0]   g_data,
    input  logic                   g_last,
    input  logic                   rd_en,
    input  logic [NET_W-1:0]       rd_id,
    output logic                   rd_valid,
    output logic                   rd_val,
    output logic                   done,
    output logic [CNT_W-1:0]       gate_cnt,
    output logic                   err_undef,
    output logic                   err_multi
);

    localparam int unsigned NETS = 1 << NET_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               g_ready_q, g_ready_d;
    logic               done_q, done_d;
    logic [NETS-1:0]    net_val_q, net_val_d;
    logic [NETS-1:0]    net_def_q, net_def_d;
    logic [CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic               err_undef_q, err_undef_d;
    logic               err_multi_q, err_multi_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_val_q, rd_val_d;

    logic [2:0]         g_op;
    logic [NET_W-1:0]   g_a, g_b, g_y;
    logic               a_v, b_v, uses_b, undef_hit, result;
    logic               restart, load_wr, accept;

    assign g_op = g_data[3*NET_W +: 3];
    assign g_a  = g_data[2*NET_W +: NET_W];
    assign g_b  = g_data[NET_W +: NET_W];
    assign g_y  = g_data[0 +: NET_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start)              state_d = S_LOAD;
            S_LOAD:         if (go_eval)            state_d = S_EVAL;
            S_EVAL:         if (g_valid && g_last)  state_d = S_DONE;
            default:                                state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered from the next state so they track state_q exactly
    always_comb begin
        g_ready_d = (state_d == S_EVAL);
        done_d    = (state_d == S_DONE);
    end

    // Gate evaluation; undefined operands read as 0, self-loops see the old value
    always_comb begin
        a_v       = net_def_q[g_a] & net_val_q[g_a];
        b_v       = net_def_q[g_b] & net_val_q[g_b];
        uses_b    = (g_op < 3'(6));
        undef_hit = !net_def_q[g_a] || (uses_b && !net_def_q[g_b]);
        case (g_op)
            3'd0:    result = a_v & b_v;
            3'd1:    result = a_v | b_v;
            3'd2:    result = ~(a_v & b_v);
            3'd3:    result = ~(a_v | b_v);
            3'd4:    result = a_v ^ b_v;
            3'd5:    result = ~(a_v ^ b_v);
            3'd6:    result = ~a_v;
            default: result = a_v;
        endcase
    end

    // Net table, counters, sticky errors and read port
    always_comb begin
        restart     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        load_wr     = pi_we && (state_q == S_LOAD);
        accept      = g_valid && (state_q == S_EVAL);
        net_val_d   = net_val_q;
        net_def_d   = net_def_q;
        gate_cnt_d  = gate_cnt_q;
        err_undef_d = err_undef_q;
        err_multi_d = err_multi_q;
        rd_valid_d  = rd_en;
        rd_val_d    = rd_en ? net_val_q[rd_id] : rd_val_q;

        if (restart) begin
            net_def_d   = '0;
            gate_cnt_d  = '0;
            err_undef_d = 1'b0;
            err_multi_d = 1'b0;
        end
        if (load_wr) begin
            net_val_d[pi_id] = pi_val;
            net_def_d[pi_id] = 1'b1;
            if (net_def_q[pi_id]) err_multi_d = 1'b1;
        end
        if (accept) begin
            net_val_d[g_y] = result;
            net_def_d[g_y] = 1'b1;
            if (net_def_q[g_y]) err_multi_d = 1'b1;
            if (undef_hit)      err_undef_d = 1'b1;
            if (gate_cnt_q != {CNT_W{1'b1}}) gate_cnt_d = gate_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_ready_q   <= 1'b0;
            done_q      <= 1'b0;
            net_val_q   <= '0;
            net_def_q   <= '0;
            gate_cnt_q  <= '0;
            err_undef_q <= 1'b0;
            err_multi_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_val_q    <= 1'b0;
        end else begin
            g_ready_q   <= g_ready_d;
            done_q      <= done_d;
            net_val_q   <= net_val_d;
            net_def_q   <= net_def_d;
            gate_cnt_q  <= gate_cnt_d;
            err_undef_q <= err_undef_d;
            err_multi_q <= err_multi_d;
            rd_valid_q  <= rd_valid_d;
            rd_val_q    <= rd_val_d;
        end
    end

    assign g_ready   = g_ready_q;
    assign done      = done_q;
    assign gate_cnt  = gate_cnt_q;
    assign err_undef = err_undef_q;
    assign err_multi = err_multi_q;
    assign rd_valid  = rd_valid_q;
    assign rd_val    = rd_val_q;

endmodule

// File: doc/gate_stream_evaluator.md
GATE_STREAM_EVALUATOR -- requirements
Module: gate_stream_evaluator

Interface
REQ-001 Parameter: NET_W, 7, net-id width; net table holds 2**NET_W one-bit nets.
REQ-002 Parameter: CNT_W, 16, width of gate counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a new evaluation run.
REQ-006 pi_we  input  1  primary-input write strobe.
REQ-007 pi_id  input  NET_W  primary-input net id.
REQ-008 pi_val  input  1  primary-input value.
REQ-009 go_eval  input  1  one-cycle pulse; ends input load, opens gate stream.
REQ-010 g_valid  input  1  gate record valid.
REQ-011 g_ready  output  1  gate record accepted when g_valid and g_ready both high.
REQ-012 g_data  input  3+3*NET_W  gate record {op[2:0], a, b, y}, y in LSBs.
REQ-013 g_last  input  1  marks final gate record of the run.
REQ-014 rd_en  input  1  net read request.
REQ-015 rd_id  input  NET_W  net id to read.
REQ-016 rd_valid  output  1  read data valid.
REQ-017 rd_val  output  1  read data.
REQ-018 done  output  1  high while in DONE.
REQ-019 gate_cnt  output  CNT_W  gates evaluated this run.
REQ-020 err_undef  output  1  sticky: gate read a net not yet defined.
REQ-021 err_multi  output  1  sticky: net driven more than once.

Function
REQ-022 FSM states IDLE, LOAD, EVAL, DONE; g_ready SHALL equal (state==EVAL).
REQ-023 start in IDLE or DONE -> LOAD, same edge clears all defined bits, gate_cnt, err_undef, err_multi; start in LOAD or EVAL ignored.
REQ-024 LOAD: pi_we writes pi_val to net pi_id and sets its defined bit; pi_we in any other state ignored; pi_we to an already-defined net overwrites and sets err_multi.
REQ-025 LOAD: go_eval -> EVAL next cycle; go_eval elsewhere ignored; pi_we and go_eval same cycle: write performed, then transition.
REQ-026 EVAL: each accepted record evaluated in the accept cycle, result written to net y and y marked defined at that edge; throughput one gate per cycle.
REQ-027 Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 BUF(a); b ignored for 6 and 7.
REQ-028 Operands read from current table state; a record may use the y of the immediately preceding record (no stall, no bubble).
REQ-029 Operand (a, or b for ops 0-5) not defined -> treated as 0, err_undef set; self-loop (a or b equals y of same record) reads old value and obeys the same rule.
REQ-030 y already defined -> result still written, err_multi set.
REQ-031 gate_cnt increments per accepted record, saturates at 2**CNT_W-1.
REQ-032 Accepted record with g_last -> DONE next cycle; g_valid outside EVAL not accepted, no effect.
REQ-033 Read port: rd_en in any state -> rd_valid=1 and rd_val=table[rd_id] next cycle; rd_valid=0 otherwise; read same cycle as write to that net returns pre-write value.
REQ-034 DONE: table, counters, errors hold until next start.

Reset
REQ-035 rst_n low asynchronously forces IDLE, clears all net values and defined bits, gate_cnt=0, err_undef=0, err_multi=0, rd_valid=0, rd_val=0, done=0, g_ready=0.
REQ-036 Reset mid-LOAD or mid-EVAL discards the run; no partial state survives.

Verification
REQ-037 start; pi 1=1, 2=0; go_eval; gates {AND a1 b2 y10},{NOR a1 b2 y11},{XOR a10 b11 y12 last} back-to-back -> done next cycle, reads of 10/11/12 return 0/0/0, gate_cnt=3, no errors.
REQ-038 Chained dependency: pi 1=1; {NOT a1 y5},{NOT a5 y6},{BUF a6 y7 last} on consecutive cycles -> net7=1, no stall, g_ready continuously high.
REQ-039 Gate reads undefined net 40 -> err_undef=1, operand treated 0; next start clears it to 0.
REQ-040 Two gates both drive y=20 -> err_multi=1, net20 holds second result.
REQ-041 g_valid held with g_ready low in LOAD, then go_eval -> first record accepted only in EVAL; gate_cnt counts it once.
REQ-042 rst_n asserted mid-EVAL after 2 gates -> immediately IDLE, gate_cnt=0, all reads return 0, done=0.
